// File: rtl/tff_count_ctrl_pkg.sv
// Shared definitions for the T-FF bank sequencer: FSM state encodings and default sizes.
package tff_count_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_LOAD = 2'd2,
      ST_RUN  = 2'd3
   } state_e;

   localparam int DEF_N      = 4;
   localparam int DEF_WRAP_W = 8;

endpackage

// File: rtl/tff_count_ctrl_step_gen.sv
// Combinational step generator: T inputs that move the bank one count up or down
// within the programmed modulus, plus a flag when that step is a wrap.
module tff_step_gen
   import tff_count_ctrl_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic [N-1:0] q,
   input  logic [N-1:0] modulus,
   input  logic         up_down,
   output logic [N-1:0] t_step,
   output logic         wrap
);

   logic [N-1:0] max_val;
   logic [N-1:0] t_inc;
   logic [N-1:0] t_dec;

   // A modulus of zero selects the full 2^N range.
   assign max_val = (modulus == '0) ? '1 : (modulus - {{(N-1){1'b0}}, 1'b1});

   assign t_inc[0] = 1'b1;
   assign t_dec[0] = 1'b1;

   generate
      for (genvar gi = 1; gi < N; gi++) begin : g_ripple
         assign t_inc[gi] = &q[gi-1:0];
         assign t_dec[gi] = &(~q[gi-1:0]);
      end
   endgenerate

   always_comb begin
      wrap   = 1'b0;
      t_step = '0;
      if (up_down) begin
         // Out-of-range values also land here, so they wrap straight to zero.
         wrap   = (q >= max_val);
         t_step = wrap ? q : t_inc;
      end else begin
         wrap   = (q == '0);
         t_step = wrap ? (q ^ max_val) : t_dec;
      end
   end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer that turns an external, unreset T-FF bank into a loadable modulo up/down
// counter: clears the bank, loads it, steps it, and counts wrap-arounds.
module tff_count_ctrl
   import tff_count_ctrl_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int WRAP_W = DEF_WRAP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              en,
   input  logic              up_down,
   input  logic [N-1:0]      load_val,
   input  logic [N-1:0]      modulus,
   input  logic [N-1:0]      q_in,
   output logic [N-1:0]      t_out,
   output logic              busy,
   output logic              tc_pulse,
   output logic [WRAP_W-1:0] wrap_cnt
);

   state_e              state_q, state_d;
   logic                tc_pulse_q, tc_pulse_d;
   logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
   logic [N-1:0]        t_step;
   logic                step_wrap;
   logic                wrap_event;

   tff_step_gen #(.N(N)) u_step_gen (
      .q       (q_in),
      .modulus (modulus),
      .up_down (up_down),
      .t_step  (t_step),
      .wrap    (step_wrap)
   );

   // stop beats both the enable and a pending wrap.
   assign wrap_event = (state_q == ST_RUN) && en && !stop && step_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: state_d = stop ? ST_IDLE : ST_RUN;
         ST_RUN:  if (stop) state_d = ST_IDLE;
         default: state_d = ST_INIT;
      endcase
   end

   // Under reset the bank is cleared straight away, so no stray step escapes.
   always_comb begin
      t_out = '0;
      busy  = 1'b0;
      if (rst) begin
         t_out = q_in;
      end else begin
         case (state_q)
            ST_INIT: t_out = q_in;
            ST_IDLE: t_out = '0;
            ST_LOAD: begin
               busy  = 1'b1;
               t_out = stop ? '0 : (q_in ^ load_val);
            end
            ST_RUN: begin
               busy  = 1'b1;
               t_out = (stop || !en) ? '0 : t_step;
            end
            default: t_out = '0;
         endcase
      end
   end

   always_comb begin
      tc_pulse_d = wrap_event;
      wrap_cnt_d = wrap_cnt_q;
      if ((state_q == ST_IDLE) && start) begin
         wrap_cnt_d = '0;
      end else if (wrap_event && (wrap_cnt_q != '1)) begin
         wrap_cnt_d = wrap_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tc_pulse_q <= 1'b0;
         wrap_cnt_q <= '0;
      end else begin
         tc_pulse_q <= tc_pulse_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign tc_pulse = tc_pulse_q;
   assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: a behavioural T-FF bank closes the loop, then directed
// vectors and a few hand-written sequences check counting, wraps, stop and reset.
module tb_tff_count_ctrl;

   localparam int N = 4;
   localparam int W = 8;

   logic          clk;
   logic          rst;
   logic          start;
   logic          stop;
   logic          en;
   logic          up_down;
   logic [N-1:0]  load_val;
   logic [N-1:0]  modulus;
   logic [N-1:0]  q_in;
   logic [N-1:0]  t_out;
   logic          busy;
   logic          tc_pulse;
   logic [W-1:0]  wrap_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   tff_count_ctrl #(.N(N), .WRAP_W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .en       (en),
      .up_down  (up_down),
      .load_val (load_val),
      .modulus  (modulus),
      .q_in     (q_in),
      .t_out    (t_out),
      .busy     (busy),
      .tc_pulse (tc_pulse),
      .wrap_cnt (wrap_cnt)
   );

   // T-FF bank with no reset; powers up in an arbitrary state.
   logic [N-1:0] bank_q;
   initial bank_q = N'($urandom);
   always @(posedge clk) bank_q <= bank_q ^ t_out;
   assign q_in = bank_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic         start;
      logic         stop;
      logic         en;
      logic         up;
      logic [N-1:0] load;
      logic [N-1:0] modv;
      logic [N-1:0] exp_q;
      logic         exp_tc;
      logic         exp_busy;
      logic [W-1:0] exp_wc;
   } vec_t;

   localparam int NV = 40;
   vec_t vecs [NV];

   function automatic vec_t mk(input int s, input int p, input int e, input int u,
                               input int ld, input int md, input int qq,
                               input int tc, input int b, input int wc);
      vec_t v;
      v.start    = s[0];
      v.stop     = p[0];
      v.en       = e[0];
      v.up       = u[0];
      v.load     = ld[N-1:0];
      v.modv     = md[N-1:0];
      v.exp_q    = qq[N-1:0];
      v.exp_tc   = tc[0];
      v.exp_busy = b[0];
      v.exp_wc   = wc[W-1:0];
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // start, stop, en, up, load, mod | q, tc, busy, wrap_cnt after the edge
      vecs[0]  = mk(1,0,1,1, 7,10,  0,0,1,0);
      vecs[1]  = mk(0,0,1,1, 7,10,  7,0,1,0);
      vecs[2]  = mk(0,0,1,1, 7,10,  8,0,1,0);
      vecs[3]  = mk(0,0,1,1, 7,10,  9,0,1,0);
      vecs[4]  = mk(0,0,1,1, 7,10,  0,1,1,1);
      vecs[5]  = mk(0,0,1,1, 7,10,  1,0,1,1);
      vecs[6]  = mk(0,1,1,1, 7,10,  1,0,0,1);
      vecs[7]  = mk(1,0,1,0, 1,10,  1,0,1,0);
      vecs[8]  = mk(0,0,1,0, 1,10,  1,0,1,0);
      vecs[9]  = mk(0,0,1,0, 1,10,  0,0,1,0);
      vecs[10] = mk(0,0,1,0, 1,10,  9,1,1,1);
      vecs[11] = mk(0,0,1,0, 1,10,  8,0,1,1);
      vecs[12] = mk(0,1,1,0, 1,10,  8,0,0,1);
      vecs[13] = mk(1,0,1,0, 0, 0,  8,0,1,0);
      vecs[14] = mk(0,0,1,0, 0, 0,  0,0,1,0);
      vecs[15] = mk(0,0,1,0, 0, 0, 15,1,1,1);
      vecs[16] = mk(0,1,1,0, 0, 0, 15,0,0,1);
      vecs[17] = mk(1,0,0,1, 3, 0, 15,0,1,0);
      vecs[18] = mk(0,0,0,1, 3, 0,  3,0,1,0);
      vecs[19] = mk(0,0,1,1, 3, 0,  4,0,1,0);
      vecs[20] = mk(0,0,0,1, 3, 0,  4,0,1,0);
      vecs[21] = mk(0,0,1,1, 3, 0,  5,0,1,0);
      vecs[22] = mk(1,0,0,1, 3, 0,  5,0,1,0);
      vecs[23] = mk(0,1,1,1, 3, 0,  5,0,0,0);
      vecs[24] = mk(0,0,1,1, 3, 0,  5,0,0,0);
      vecs[25] = mk(1,0,1,1,12,10,  5,0,1,0);
      vecs[26] = mk(0,0,1,1,12,10, 12,0,1,0);
      vecs[27] = mk(0,0,1,1,12,10,  0,1,1,1);
      vecs[28] = mk(0,1,1,1,12,10,  0,0,0,1);
      vecs[29] = mk(1,0,1,1, 0, 1,  0,0,1,0);
      vecs[30] = mk(0,0,1,1, 0, 1,  0,0,1,0);
      vecs[31] = mk(0,0,1,1, 0, 1,  0,1,1,1);
      vecs[32] = mk(0,0,1,0, 0, 1,  0,1,1,2);
      vecs[33] = mk(0,0,1,1, 0, 1,  0,1,1,3);
      vecs[34] = mk(0,1,1,1, 0, 1,  0,0,0,3);
      vecs[35] = mk(1,1,0,1, 9, 0,  0,0,1,0);
      vecs[36] = mk(0,1,0,1, 9, 0,  0,0,0,0);
      vecs[37] = mk(1,0,1,1, 9,10,  0,0,1,0);
      vecs[38] = mk(0,0,1,1, 9,10,  9,0,1,0);
      vecs[39] = mk(0,1,1,1, 9,10,  9,0,0,0);

      rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; up_down = 1'b1;
      load_val = '0; modulus = '0;

      // Reset clears the bank one edge into reset.
      tick();
      chk("rst_q_clear", int'(q_in), 0);
      tick();
      rst = 1'b0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_tc", int'(tc_pulse), 0);
      chk("rst_wrap_cnt", int'(wrap_cnt), 0);
      tick();
      chk("idle_t_out", int'(t_out), 0);
      chk("idle_q", int'(q_in), 0);
      $display("reset: q=%0d t_out=%0d busy=%0d", q_in, t_out, busy);

      for (int i = 0; i < NV; i++) begin
         start = vecs[i].start; stop = vecs[i].stop; en = vecs[i].en;
         up_down = vecs[i].up; load_val = vecs[i].load; modulus = vecs[i].modv;
         tick();
         $display("vec %0d: q=%0d tc=%0d busy=%0d wrap_cnt=%0d", i, q_in, tc_pulse, busy, wrap_cnt);
         chk($sformatf("vec%0d_q", i), int'(q_in), int'(vecs[i].exp_q));
         chk($sformatf("vec%0d_tc", i), int'(tc_pulse), int'(vecs[i].exp_tc));
         chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_wrap_cnt", i), int'(wrap_cnt), int'(vecs[i].exp_wc));
      end

      // Saturation: modulus 1 wraps every enabled cycle; 300+ wraps pin the counter.
      start = 1'b1; stop = 1'b0; en = 1'b1; up_down = 1'b1; load_val = '0; modulus = 4'd1;
      tick();
      start = 1'b0;
      repeat (305) tick();
      $display("saturate: q=%0d tc=%0d wrap_cnt=%0d", q_in, tc_pulse, wrap_cnt);
      chk("sat_wrap_cnt", int'(wrap_cnt), 255);
      chk("sat_tc", int'(tc_pulse), 1);
      chk("sat_q", int'(q_in), 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;

      // Reset mid-run with a wrap pending at q=6, modulus 7.
      start = 1'b1; en = 1'b1; up_down = 1'b1; load_val = 4'd6; modulus = 4'd7;
      tick();
      start = 1'b0;
      tick();
      chk("mid_q_before", int'(q_in), 6);
      rst = 1'b1;
      #1;
      chk("mid_t_out_rst", int'(t_out), 6);
      tick();
      $display("mid-run reset: q=%0d tc=%0d wrap_cnt=%0d busy=%0d", q_in, tc_pulse, wrap_cnt, busy);
      chk("mid_q_zero", int'(q_in), 0);
      chk("mid_tc", int'(tc_pulse), 0);
      chk("mid_wrap_cnt", int'(wrap_cnt), 0);
      chk("mid_busy", int'(busy), 0);
      rst = 1'b0;
      tick();
      chk("post_q", int'(q_in), 0);
      chk("post_tc", int'(tc_pulse), 0);
      chk("post_t_out", int'(t_out), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
